// File: rtl/pixel_buffer_pkg.sv
// Shared state type and default screen geometry for the fractal pixel buffer.
package pixel_buffer_pkg;

  typedef enum logic [0:0] {PB_IDLE, PB_CLEAR} pb_state_t;

  localparam int unsigned SCREEN_W = 640;
  localparam int unsigned SCREEN_H = 480;

endpackage

// File: rtl/pixel_buffer_ram.sv
// Simple dual-port synchronous RAM, read-before-write, block-RAM inferable.
module pixel_buffer_ram #(
  parameter int unsigned DEPTH      = 307200,
  parameter int unsigned PIXEL_BITS = 4,
  localparam int unsigned AW        = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [PIXEL_BITS-1:0] wdata,
  input  logic                  re,
  input  logic [AW-1:0]         raddr,
  output logic [PIXEL_BITS-1:0] rdata
);

  logic [PIXEL_BITS-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/pixel_frame_buffer.sv
// Frame buffer between fractal_engine and the colorizer: handshaked pixel writes,
// 2-cycle beam-coordinate reads, hardware clear sweep and frame-completion pulse.
module pixel_frame_buffer
  import pixel_buffer_pkg::*;
#(
  parameter int unsigned WIDTH       = SCREEN_W,
  parameter int unsigned HEIGHT      = SCREEN_H,
  parameter int unsigned PIXEL_BITS  = 4,
  parameter int unsigned CLEAR_VALUE = 0,
  localparam int unsigned DEPTH      = WIDTH * HEIGHT,
  localparam int unsigned AW         = $clog2(DEPTH),
  localparam int unsigned XW         = $clog2(WIDTH),
  localparam int unsigned YW         = $clog2(HEIGHT)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear_req,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [XW-1:0]         wr_x,
  input  logic [YW-1:0]         wr_y,
  input  logic [PIXEL_BITS-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [9:0]            rd_x,
  input  logic [9:0]            rd_y,
  output logic                  rd_valid,
  output logic [PIXEL_BITS-1:0] rd_data,
  output logic                  clearing,
  output logic                  wr_oob,
  output logic                  frame_done
);

  pb_state_t             state_q, state_d;
  logic [AW-1:0]         clr_addr_q, clr_addr_d, wr_cnt_q, wr_cnt_d;
  logic [AW-1:0]         wr_addr, rd_addr, ram_waddr;
  logic [PIXEL_BITS-1:0] ram_wdata, ram_rdata, rd_data_q;
  logic                  ram_we, wr_fire, wr_inr, wr_last, rd_inr;
  logic                  wr_ready_q, wr_oob_q, frame_done_q;
  logic                  rd_s1_valid_q, rd_s1_inr_q, rd_s1_clr_q, rd_valid_q;

  assign wr_fire = wr_valid && wr_ready_q;
  assign wr_inr  = (32'(wr_x) < WIDTH) && (32'(wr_y) < HEIGHT);
  assign rd_inr  = (32'(rd_x) < WIDTH) && (32'(rd_y) < HEIGHT);
  assign wr_addr = AW'(32'(wr_y) * WIDTH + 32'(wr_x));
  assign rd_addr = AW'(32'(rd_y) * WIDTH + 32'(rd_x));
  assign wr_last = (wr_cnt_q == AW'(DEPTH - 1));

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    wr_cnt_d   = wr_cnt_q;
    ram_we     = 1'b0;
    ram_waddr  = wr_addr;
    ram_wdata  = wr_data;
    unique case (state_q)
      PB_IDLE: begin
        if (wr_fire && wr_inr) begin
          ram_we   = 1'b1;
          wr_cnt_d = wr_last ? '0 : wr_cnt_q + 1'b1;
        end
        if (clear_req) begin
          state_d    = PB_CLEAR;
          clr_addr_d = '0;
        end
      end
      PB_CLEAR: begin
        ram_we    = 1'b1;
        ram_waddr = clr_addr_q;
        ram_wdata = PIXEL_BITS'(CLEAR_VALUE);
        if (clr_addr_q == AW'(DEPTH - 1)) begin
          state_d    = PB_IDLE;
          clr_addr_d = '0;
          wr_cnt_d   = '0;
        end else begin
          clr_addr_d = clr_addr_q + 1'b1;
        end
      end
      default: state_d = PB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= PB_IDLE;
      clr_addr_q    <= '0;
      wr_cnt_q      <= '0;
      wr_ready_q    <= 1'b0;
      wr_oob_q      <= 1'b0;
      frame_done_q  <= 1'b0;
      rd_s1_valid_q <= 1'b0;
      rd_s1_inr_q   <= 1'b0;
      rd_s1_clr_q   <= 1'b0;
      rd_valid_q    <= 1'b0;
      rd_data_q     <= PIXEL_BITS'(CLEAR_VALUE);
    end else begin
      state_q       <= state_d;
      clr_addr_q    <= clr_addr_d;
      wr_cnt_q      <= wr_cnt_d;
      wr_ready_q    <= (state_d == PB_IDLE);
      wr_oob_q      <= wr_fire && !wr_inr;
      frame_done_q  <= wr_fire && wr_inr && wr_last;
      rd_s1_valid_q <= rd_en;
      rd_s1_inr_q   <= rd_inr;
      // A read racing the final sweep write would otherwise see stale data.
      rd_s1_clr_q   <= (state_q == PB_CLEAR);
      rd_valid_q    <= rd_s1_valid_q;
      if (rd_s1_valid_q) begin
        rd_data_q <= (rd_s1_inr_q && !rd_s1_clr_q && state_q == PB_IDLE) ?
                     ram_rdata : PIXEL_BITS'(CLEAR_VALUE);
      end
    end
  end

  pixel_buffer_ram #(
    .DEPTH      (DEPTH),
    .PIXEL_BITS (PIXEL_BITS)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (rd_en && rd_inr),
    .raddr (rd_addr),
    .rdata (ram_rdata)
  );

  assign wr_ready   = wr_ready_q;
  assign wr_oob     = wr_oob_q;
  assign frame_done = frame_done_q;
  assign rd_valid   = rd_valid_q;
  assign rd_data    = rd_data_q;
  assign clearing   = (state_q == PB_CLEAR);

endmodule

// File: tb/tb_pixel_frame_buffer.sv
// Randomised bench for pixel_frame_buffer: an 8x4 instance against a behavioural
// pixel-array model, plus a 6x3 instance where out-of-range writes are representable.
module tb_pixel_frame_buffer;

  localparam int W = 8, H = 4, D = W * H;
  localparam int BW = 6, BH = 3, BD = BW * BH;

  logic       clk = 1'b0, reset = 1'b0, clear_req = 1'b0;
  logic       wr_valid = 1'b0, rd_en = 1'b0;
  logic [2:0] wr_x = '0;
  logic [1:0] wr_y = '0;
  logic [3:0] wr_data = '0;
  logic [9:0] rd_x = '0, rd_y = '0;
  logic       wr_ready, rd_valid, clearing, wr_oob, frame_done;
  logic [3:0] rd_data;

  logic       b_wr_valid = 1'b0, b_rd_en = 1'b0;
  logic [2:0] b_wr_x = '0;
  logic [1:0] b_wr_y = '0;
  logic [3:0] b_wr_data = '0;
  logic [9:0] b_rd_x = '0, b_rd_y = '0;
  logic       b_wr_ready, b_rd_valid, b_clearing, b_wr_oob, b_frame_done;
  logic [3:0] b_rd_data;

  always #5 clk = ~clk;

  pixel_frame_buffer #(.WIDTH(W), .HEIGHT(H), .PIXEL_BITS(4), .CLEAR_VALUE(0)) dut (
    .clk(clk), .reset(reset), .clear_req(clear_req), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data), .rd_en(rd_en),
    .rd_x(rd_x), .rd_y(rd_y), .rd_valid(rd_valid), .rd_data(rd_data),
    .clearing(clearing), .wr_oob(wr_oob), .frame_done(frame_done)
  );

  pixel_frame_buffer #(.WIDTH(BW), .HEIGHT(BH), .PIXEL_BITS(4), .CLEAR_VALUE(0)) dut_b (
    .clk(clk), .reset(reset), .clear_req(clear_req), .wr_valid(b_wr_valid),
    .wr_ready(b_wr_ready), .wr_x(b_wr_x), .wr_y(b_wr_y), .wr_data(b_wr_data),
    .rd_en(b_rd_en), .rd_x(b_rd_x), .rd_y(b_rd_y), .rd_valid(b_rd_valid),
    .rd_data(b_rd_data), .clearing(b_clearing), .wr_oob(b_wr_oob),
    .frame_done(b_frame_done)
  );

  int n_cmp = 0, n_bad = 0;

  // Reference model: pixel array, frame counter, sweep countdown, read delay line.
  logic [3:0] mem [D];
  logic [3:0] bmem [BD];
  int         cnt = 0, clr_left = 0;
  bit         exp_clearing = 1'b0, exp_ready = 1'b0, exp_oob = 1'b0, exp_fd = 1'b0;
  bit         pv [2];
  logic [3:0] pd [2];
  logic [3:0] exp_rd = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    exp_clearing = (clr_left > 0);
    exp_ready    = !exp_clearing;
    check("clearing", 32'(clearing), 32'(exp_clearing));
    check("wr_ready", 32'(wr_ready), 32'(exp_ready));
    check("rd_valid", 32'(rd_valid), 32'(pv[1]));
    if (pv[1]) exp_rd = pd[1];
    check("rd_data", 32'(rd_data), 32'(exp_rd));
    check("wr_oob", 32'(wr_oob), 32'(exp_oob));
    check("frame_done", 32'(frame_done), 32'(exp_fd));
    if (clr_left > 0) clr_left--;
    pv[1] = pv[0];
    pd[1] = pd[0];
    pv[0] = 1'b0;
    exp_oob = 1'b0;
    exp_fd  = 1'b0;
    wr_valid  = 1'b0;
    rd_en     = 1'b0;
    clear_req = 1'b0;
  endtask

  task automatic apply(input bit wv, input int x, input int y, input int d,
                       input bit re, input int rx, input int ry, input bit clr);
    bit clr_go;
    logic [4:0] a;
    wr_valid = wv; wr_x = 3'(x); wr_y = 2'(y); wr_data = 4'(d);
    rd_en = re; rd_x = 10'(rx); rd_y = 10'(ry); clear_req = clr;
    clr_go = clr && !exp_clearing;
    if (re) begin
      a = 5'(ry * W + rx);
      pv[0] = 1'b1;
      pd[0] = (rx < W && ry < H && !clr_go) ? mem[a] : 4'h0;
    end
    if (wv && exp_ready) begin
      a = 5'(y * W + x);
      mem[a] = 4'(d);
      cnt++;
      if (cnt == D) begin
        cnt = 0;
        exp_fd = 1'b1;
      end
    end
    if (clr_go) begin
      clr_left = D;
      cnt = 0;
      foreach (mem[i]) mem[i] = 4'h0;
    end
  endtask

  task automatic b_write(input int x, input int y, input int d, input bit eo, input bit ef);
    check("b_wr_ready", 32'(b_wr_ready), 32'(1));
    b_wr_valid = 1'b1; b_wr_x = 3'(x); b_wr_y = 2'(y); b_wr_data = 4'(d);
    @(negedge clk);
    b_wr_valid = 1'b0;
    check("b_wr_oob", 32'(b_wr_oob), 32'(eo));
    check("b_frame_done", 32'(b_frame_done), 32'(ef));
  endtask

  task automatic b_read(input int x, input int y, input logic [3:0] exp);
    b_rd_en = 1'b1; b_rd_x = 10'(x); b_rd_y = 10'(y);
    @(negedge clk);
    b_rd_en = 1'b0;
    check("b_rd_valid_early", 32'(b_rd_valid), 32'(0));
    @(negedge clk);
    check("b_rd_valid", 32'(b_rd_valid), 32'(1));
    check("b_rd_data", 32'(b_rd_data), 32'(exp));
  endtask

  task automatic model_reset();
    pv[0] = 1'b0; pv[1] = 1'b0;
    exp_rd = 4'h0; cnt = 0; clr_left = 0;
    exp_oob = 1'b0; exp_fd = 1'b0; exp_ready = 1'b0; exp_clearing = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1);
  end

  initial begin
    int perm [D];
    foreach (mem[i]) mem[i] = 4'h0;
    pv[0] = 1'b0; pv[1] = 1'b0; pd[0] = 4'h0; pd[1] = 4'h0;

    #1;
    check("rst_wr_ready", 32'(wr_ready), 32'(0));
    check("rst_rd_valid", 32'(rd_valid), 32'(0));
    check("rst_rd_data", 32'(rd_data), 32'(0));
    check("rst_clearing", 32'(clearing), 32'(0));
    check("rst_frame_done", 32'(frame_done), 32'(0));
    repeat (2) @(negedge clk);
    reset = 1'b1;
    tick();

    // Clear sweep, then read every pixel back-to-back plus blanking coordinates.
    apply(0, 0, 0, 0, 0, 0, 0, 1);
    repeat (D + 2) tick();
    for (int p = 0; p < D; p++) begin
      apply(0, 0, 0, 0, 1, p % W, p / W, 0);
      tick();
    end
    apply(0, 0, 0, 0, 1, 9, 5, 0);
    tick();
    apply(0, 0, 0, 0, 1, W, 0, 0);
    repeat (3) tick();

    // Whole frame in random order with random idle gaps.
    for (int i = 0; i < D; i++) perm[i] = i;
    for (int i = D - 1; i > 0; i--) begin
      int j, t;
      j = int'($urandom_range(0, i));
      t = perm[i]; perm[i] = perm[j]; perm[j] = t;
    end
    for (int i = 0; i < D; i++) begin
      apply(1, perm[i] % W, perm[i] / W, int'($urandom_range(0, 15)), 0, 0, 0, 0);
      tick();
      repeat ($urandom_range(0, 2)) tick();
    end
    repeat (2) tick();

    // Latency and hold.
    apply(1, 3, 2, 4'hA, 0, 0, 0, 0);
    tick();
    apply(0, 0, 0, 0, 1, 3, 2, 0);
    repeat (5) tick();

    // Same-cycle read and write to one pixel returns the old value.
    apply(1, 1, 1, 4'h3, 0, 0, 0, 0);
    tick();
    apply(1, 1, 1, 4'h7, 1, 1, 1, 0);
    tick();
    apply(0, 0, 0, 0, 1, 1, 1, 0);
    repeat (3) tick();

    // Out-of-range writes on the 6x3 instance; its counter must ignore them.
    for (int a = 0; a < BD - 1; a++) begin
      bmem[5'(a)] = 4'((a * 7 + 3) & 15);
      b_write(a % BW, a / BW, int'(bmem[5'(a)]), 0, 0);
    end
    b_write(7, 0, 15, 1, 0);
    b_write(6, 1, 15, 1, 0);
    b_write(0, 3, 15, 1, 0);
    b_write(7, 3, 15, 1, 0);
    bmem[5'(BD - 1)] = 4'h9;
    b_write((BD - 1) % BW, (BD - 1) / BW, 9, 0, 1);
    b_read(1, 1, bmem[5'd7]);
    b_read(0, 2, bmem[5'd12]);
    b_read(5, 2, bmem[5'd17]);
    b_read(9, 5, 4'h0);

    // Clear requested alongside a read; a second request mid-sweep is ignored.
    apply(1, 5, 3, 4'h9, 0, 0, 0, 0);
    tick();
    apply(0, 0, 0, 0, 1, 5, 3, 1);
    repeat (5) tick();
    apply(0, 0, 0, 0, 1, 2, 2, 1);
    repeat (D + 2) tick();

    // Random mixed traffic, occasional clears.
    for (int n = 0; n < 400; n++) begin
      apply(bit'($urandom_range(0, 1)), int'($urandom_range(0, W - 1)),
            int'($urandom_range(0, H - 1)), int'($urandom_range(0, 15)),
            bit'($urandom_range(0, 1)), int'($urandom_range(0, W + 3)),
            int'($urandom_range(0, H + 2)), ($urandom_range(0, 127) == 0));
      tick();
    end
    repeat (D + 2) tick();

    // Asynchronous reset ten cycles into a sweep with a read in flight.
    apply(0, 0, 0, 0, 0, 0, 0, 1);
    repeat (9) tick();
    apply(0, 0, 0, 0, 1, 2, 1, 0);
    tick();
    #2 reset = 1'b0;
    #1;
    check("midrst_clearing", 32'(clearing), 32'(0));
    check("midrst_wr_ready", 32'(wr_ready), 32'(0));
    check("midrst_rd_valid", 32'(rd_valid), 32'(0));
    check("midrst_rd_data", 32'(rd_data), 32'(0));
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    check("release_wr_ready", 32'(wr_ready), 32'(0));
    tick();
    apply(0, 0, 0, 0, 0, 0, 0, 1);
    repeat (D + 2) tick();
    for (int n = 0; n < 60; n++) begin
      apply(bit'($urandom_range(0, 1)), int'($urandom_range(0, W - 1)),
            int'($urandom_range(0, H - 1)), int'($urandom_range(0, 15)),
            bit'($urandom_range(0, 1)), int'($urandom_range(0, W + 3)),
            int'($urandom_range(0, H + 2)), 1'b0);
      tick();
    end
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pixel_frame_buffer.md
Name: pixel_frame_buffer

Overview:
- Parametrised, single-clock successor to the fractal pixel buffer. It stores one escape or colour index per screen pixel.
- The fractal engine writes pixels through a valid/ready handshake. The VGA/colorizer side reads pixels by beam coordinate with a fixed 2-cycle latency.
- Adds two behaviours the previous block lacked: a hardware clear sweep and frame-completion tracking.
- Sits between fractal_engine and colorize_pixel_unit.

Parameters:
- WIDTH, 640, visible pixels per line.
- HEIGHT, 480, visible lines.
- PIXEL_BITS, 4, bits stored per pixel.
- CLEAR_VALUE, 0, value written by the clear sweep and returned for out-of-range reads.
- Derived (localparam): DEPTH = WIDTH*HEIGHT; AW = $clog2(DEPTH); XW = $clog2(WIDTH); YW = $clog2(HEIGHT).

Ports:
- clk  in  1  system clock; sole clock domain.
- reset  in  1  asynchronous, active-low reset.
- clear_req  in  1  single-cycle pulse; starts a clear sweep.
- wr_valid  in  1  write request valid.
- wr_ready  out  1  write accepted on a cycle where wr_valid && wr_ready.
- wr_x  in  XW  write column.
- wr_y  in  YW  write row.
- wr_data  in  PIXEL_BITS  pixel value to store.
- rd_en  in  1  read strobe (VGA pixel tick).
- rd_x  in  10  beam column (drawxsig).
- rd_y  in  10  beam row (drawysig).
- rd_valid  out  1  rd_data updated this cycle.
- rd_data  out  PIXEL_BITS  pixel value; holds its last value between reads.
- clearing  out  1  high while the clear sweep runs.
- wr_oob  out  1  one-cycle pulse when an accepted write is out of range.
- frame_done  out  1  one-cycle pulse when the frame is complete.

Behaviour:
- Reset values (while reset=0): FSM=IDLE, wr_ready=0, rd_valid=0, rd_data=CLEAR_VALUE, clearing=0, wr_oob=0, frame_done=0, write counter=0.
- RAM contents are not reset. Software issues clear_req after reset.
- wr_ready=1 the first cycle after reset deasserts, provided FSM=IDLE.
- FSM states:
  - IDLE: wr_ready=1. clear_req -> CLEAR next cycle, with wr_ready=0 from that cycle.
  - CLEAR: clearing=1, wr_ready=0. Writes CLEAR_VALUE to address clr_addr, one address per cycle, from 0 to DEPTH-1. After writing DEPTH-1 -> IDLE. The sweep takes exactly DEPTH cycles; the write counter is zeroed on exit.
- clear_req while in CLEAR is ignored; the sweep does not restart.
- clear_req in the same cycle as a write handshake: the write completes and the clear starts next cycle.
- Write address = wr_y*WIDTH + wr_x, computed combinationally; the RAM write happens on the handshake edge.
- Out-of-range writes (wr_x>=WIDTH or wr_y>=HEIGHT): still handshaked, RAM not written, wr_oob pulses the next cycle, counter not incremented.
- Write counter counts in-range accepted writes. When it would reach DEPTH: frame_done pulses next cycle and the counter wraps to 0.
- Duplicate coordinates are counted. The producer guarantees each pixel is written once per frame.
- Read pipeline:
  - Cycle 0: rd_en sampled; address (rd_y*WIDTH + rd_x) and range flag registered.
  - Cycle 1: synchronous RAM read.
  - Cycle 2: rd_data and rd_valid=1 registered.
- rd_data holds its value when no read completes; rd_valid=0 on those cycles.
- Back-to-back reads give one result per cycle.
- Reads with rd_x>=WIDTH or rd_y>=HEIGHT (blanking region) return CLEAR_VALUE, with rd_valid=1.
- Reads whose cycle 1 falls during CLEAR return CLEAR_VALUE.
- Read and write to the same address in the same cycle: the read returns the old data (read-before-write).
- Asynchronous reset mid-sweep or mid-read: the FSM returns to IDLE immediately and the pipeline valids clear. A partially cleared RAM is acceptable.

Decomposition:
- Package pixel_buffer_pkg holds:
  - typedef enum logic [0:0] {PB_IDLE, PB_CLEAR} pb_state_t;
  - default SCREEN_W/SCREEN_H constants shared with address_translation_unit.
- One sub-module, pixel_buffer_ram: simple dual-port synchronous RAM, parameters DEPTH and PIXEL_BITS, one write port and one read port on clk, read-before-write, inferable as block RAM.

Test Plan (WIDTH=8, HEIGHT=4, PIXEL_BITS=4, CLEAR_VALUE=0):
- Reset then clear: pulse reset, then clear_req -> clearing high exactly 32 cycles, wr_ready=0 throughout; afterwards reads of all 32 pixels return 0.
- Write/read latency: write (3,2)=0xA, then rd_en at (3,2) -> rd_valid and rd_data=0xA exactly 2 cycles after the strobe; rd_data holds 0xA while rd_en=0.
- Frame completion: write all 32 in-range pixels with random wr_valid gaps -> frame_done pulses once, the cycle after the 32nd handshake; counter wraps to 0.
- Out-of-range: write (8,0)=0xF -> handshake occurs, wr_oob pulses, pixel (0,1) unchanged, frame_done not advanced; read (9,5) -> rd_data=0.
- Collision: (1,1)=0x3 stored; same cycle write (1,1)=0x7 and read (1,1) -> read returns 0x3; next read returns 0x7.
- Reset mid-sweep: assert reset at sweep cycle 10 -> clearing=0 and wr_ready=0 immediately; wr_ready=1 one cycle after release.
